// File: rtl/ysyx_24100012_inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one word request at a time to instruction memory
// and hands each fetched word with its PC to the decoder. Redirects squash in-flight work.
module ysyx_24100012_inst_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StErr} state_e;

  state_e                  state;
  logic [DATA_WIDTH-1:0]   pc;
  logic                    drop;
  logic                    req_fire;
  logic [DATA_WIDTH-1:0]   redirect_target;

  // Request is masked while reset is held even though the state already reads StReq.
  assign imem_req_valid  = (state == StReq) && !rst;
  assign inst_valid      = (state == StHold);
  assign imem_addr       = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StReq;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        StReq: begin
          if (req_fire) begin
            state <= StWait;
            // A redirect racing the handshake poisons the response already requested.
            drop  <= redirect_valid;
          end
          if (redirect_valid) pc <= redirect_target;
        end
        StWait: begin
          if (redirect_valid) pc <= redirect_target;
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= StReq;
            end else if (imem_rsp_err) begin
              fetch_err <= 1'b1;
              state     <= StErr;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              state   <= StHold;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc    <= redirect_target;
            state <= StReq;
          end else if (inst_ready) begin
            pc    <= pc + DATA_WIDTH'(4);
            state <= StReq;
          end
        end
        StErr: begin
          state <= StErr;
        end
      endcase
    end
  end

endmodule
